// File: rtl/barrett_reduce_stream.sv
// Streaming Barrett reducer r = x mod q with valid/ready on both sides and a tag sideband.
// Optional BARRETT_MODMUL_EN adds y_i and a multiply stage S0, giving (x_i[DATA_W-1:0]*y_i) mod q.
module barrett_reduce_stream #(
  parameter int DATA_W = 32,
  parameter int X_W    = 2*DATA_W,
  parameter int MU_W   = DATA_W+2,
  parameter int TAG_W  = 8
) (
  input  logic              CLK_pci_sys_clk_p,
  input  logic              rst_ni,
  input  logic              cfg_we_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] q_bl_i,
  input  logic [MU_W-1:0]   mu_i,
  output logic              cfg_err_o,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [X_W-1:0]    x_i,
`ifdef BARRETT_MODMUL_EN
  input  logic [DATA_W-1:0] y_i,
`endif
  input  logic [TAG_W-1:0]  tag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] result_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic              busy_o
);

`ifdef BARRETT_MODMUL_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif
  localparam int RW = DATA_W + 2;
  localparam int PW = X_W + MU_W;

  logic [DATA_W-1:0]           r_q, r_k;
  logic [MU_W-1:0]             r_mu;
  logic                        r_cfg_err;
  logic [LAT:1]                r_vld_pipe;
  logic [LAT:1][TAG_W-1:0]     r_tag_pipe;

  logic w_stall, w_en, w_acc, w_busy;

  assign w_stall = r_vld_pipe[LAT] & ~ready_i;
  assign w_en    = ~w_stall;
  assign w_acc   = valid_i & ~w_stall;
  assign w_busy  = |r_vld_pipe;

  assign ready_o   = ~w_stall;
  assign valid_o   = r_vld_pipe[LAT];
  assign tag_o     = r_tag_pipe[LAT];
  assign busy_o    = w_busy;
  assign cfg_err_o = r_cfg_err;

  // Config only changes while the pipe is empty, so live registers are the
  // accept-time config for every item in flight.
  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q       <= '0;
      r_k       <= '0;
      r_mu      <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we_i & (w_busy | w_acc);
      if (cfg_we_i && !w_busy && !w_acc) begin
        r_q  <= q_i;
        r_k  <= q_bl_i;
        r_mu <= mu_i;
      end
    end
  end

  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_pipe <= '0;
      r_tag_pipe <= '0;
    end else if (w_en) begin
      r_vld_pipe <= {r_vld_pipe[LAT-1:1], w_acc};
      r_tag_pipe <= {r_tag_pipe[LAT-1:1], tag_i};
    end
  end

  logic [X_W-1:0] w_x_in;

`ifdef BARRETT_MODMUL_EN
  logic [X_W-1:0] r_s0_x;
  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni)   r_s0_x <= '0;
    else if (w_en) r_s0_x <= X_W'(x_i[DATA_W-1:0]) * X_W'(y_i);
  end
  assign w_x_in = r_s0_x;
`else
  assign w_x_in = x_i;
`endif

  logic [DATA_W-1:0] w_km1, w_kp1;
  logic [RW-1:0]     r_s1_x, r_s2_x, r_s3_x, r_s3_t, r_s4_r0;
  logic [X_W-1:0]    r_s1_q1;
  logic [PW-1:0]     r_s2_q2;
  logic [RW-1:0]     w_q3, w_t, w_qe, w_2q, w_r;
  logic [DATA_W-1:0] r_res;

  assign w_km1 = r_k - DATA_W'(1);
  assign w_kp1 = r_k + DATA_W'(1);
  assign w_q3  = RW'(r_s2_q2 >> w_kp1);
  // Only the low RW bits of t matter: x - t is taken modulo 2^RW.
  assign w_t   = w_q3 * RW'(r_q);
  assign w_qe  = RW'(r_q);
  assign w_2q  = w_qe << 1;

  always_comb begin
    w_r = r_s4_r0;
    if (r_s4_r0 >= w_2q)     w_r = r_s4_r0 - w_2q;
    else if (r_s4_r0 >= w_qe) w_r = r_s4_r0 - w_qe;
  end

  always_ff @(posedge CLK_pci_sys_clk_p or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_x  <= '0;
      r_s1_q1 <= '0;
      r_s2_x  <= '0;
      r_s2_q2 <= '0;
      r_s3_x  <= '0;
      r_s3_t  <= '0;
      r_s4_r0 <= '0;
      r_res   <= '0;
    end else if (w_en) begin
      r_s1_x  <= w_x_in[RW-1:0];
      r_s1_q1 <= w_x_in >> w_km1;
      r_s2_x  <= r_s1_x;
      r_s2_q2 <= PW'(r_s1_q1) * PW'(r_mu);
      r_s3_x  <= r_s2_x;
      r_s3_t  <= w_t;
      r_s4_r0 <= r_s3_x - r_s3_t;
      r_res   <= DATA_W'(w_r);
    end
  end

  assign result_o = r_res;

endmodule

// File: doc/barrett_reduce_stream.md
Name: barrett_reduce_stream

Overview:
Parametrised, fully pipelined Barrett reducer. Computes r = x mod q for a stream of operands, with a valid/ready handshake on both sides and a per-item tag carried alongside the data. The modulus configuration (q, bitlength k, mu) is held in a register that is written through a config port. Successor to the fixed-width barrett_pipelined core; sits between the NTT/polynomial datapath and its result buffers (Dilithium q = 8380417 by default).

Parameters:
DATA_W, 32, width of q and of the result r
X_W, 2*DATA_W, width of the input operand x
MU_W, DATA_W+2, width of mu
TAG_W, 8, width of the sideband tag passed through unchanged
LAT, 5, pipeline depth in cycles; fixed by the stage split and not user-tunable

Ports:
CLK_pci_sys_clk_p  in  1  rising-edge clock
rst_ni  in  1  asynchronous active-low reset
cfg_we_i  in  1  config write strobe
q_i  in  DATA_W  modulus
q_bl_i  in  DATA_W  modulus bitlength k
mu_i  in  MU_W  precomputed floor(2^(2k)/q)
cfg_err_o  out  1  one-cycle pulse: config write rejected
valid_i  in  1  input operand valid
ready_o  out  1  core can accept an operand
x_i  in  X_W  operand; x < 2^(2k) required
tag_i  in  TAG_W  sideband tag
valid_o  out  1  result valid
ready_i  in  1  downstream accepts the result
result_o  out  DATA_W  x mod q
tag_o  out  TAG_W  tag of that result
busy_o  out  1  at least one pipeline stage holds a valid item

Behaviour:
- Reset (asynchronous, active-low):
  - all stage valid bits = 0
  - valid_o = 0, result_o = 0, tag_o = 0, busy_o = 0, cfg_err_o = 0
  - config registers = 0
  - an in-flight item is dropped silently if reset occurs mid-stream.
- Config write:
  - With cfg_we_i = 1 and busy_o = 0 and no accept this cycle, q/k/mu are latched at the clock edge.
  - If busy_o = 1, or valid_i && ready_o in the same cycle, the write is ignored and cfg_err_o pulses high for 1 cycle.
  - Items in flight always use the config that was active when they were accepted.
- Handshake:
  - Accept when valid_i && ready_o.
  - Transfer out when valid_o && ready_i.
  - stall = valid_o && !ready_i; ready_o = !stall (combinational).
  - On stall every stage holds its contents; no bubble collapse.
  - Output data and tag stay stable while valid_o && !ready_i.
- Pipeline, one register per stage, unsigned arithmetic throughout:
  - S1: q1 = x >> (k-1).
  - S2: q2 = q1 * mu, kept at full width.
  - S3: q3 = q2 >> (k+1); t = q3 * q.
  - S4: r0 = x - t, computed modulo 2^(DATA_W+2), which is sufficient because r0 < 3q.
  - S5: if r0 >= 2q then r = r0 - 2q; else if r0 >= q then r = r0 - q; else r = r0. Register r into result_o.
- Timing:
  - Latency is LAT = 5 cycles from accept to valid_o when there is no stall.
  - Throughput is 1 item per cycle.
  - Results leave in order; tag_i travels with its operand.
- busy_o = OR of all stage valid bits, including the output stage.
- Boundaries:
  - x = 0 -> 0.
  - x = q -> 0.
  - x = q-1 -> q-1.
  - x = 2^(2k)-1 is supported.
  - x >= 2^(2k) is undefined but must not hang the pipeline.
  - Simultaneous accept and transfer in the same cycle is legal.
  - ready_i low for any number of cycles loses nothing.

Optional Feature:
BARRETT_MODMUL_EN
- Defined: adds port y_i (in, DATA_W) and a stage S0 that computes x = x_i[DATA_W-1:0] * y_i. LAT becomes 6. Block computes (a*b) mod q for modular-multiply use in the NTT.
- Undefined: no y_i port; x_i is reduced directly; LAT = 5.

Test Plan:
1. Config q=8380417, k=23, mu=8396807; stream x = 0, 8380417, 8380416, 70368744177663 with ready_i=1 -> results 0, 0, 8380416, 49144 at 5, 6, 7, 8 cycles after the first accept; tags are echoed.
2. Back-to-back burst of 16 random x < 2^46, then ready_i=0 for 7 cycles mid-burst -> valid_o and result_o hold, ready_o=0, all 16 results arrive in order and match x % q.
3. cfg_we_i with a new q=3329, k=12, mu=5039 while 3 items are in flight -> cfg_err_o pulses once; the 3 results use q=8380417. After the pipeline drains, the same write is accepted and x=3329*5+7 -> 7.
4. Assert rst_ni low for 1 cycle with 4 items in flight -> valid_o=0 and busy_o=0 immediately; no stale outputs after release. A new x=10 -> 10.
5. With BARRETT_MODMUL_EN: a=8380416, b=8380416 -> 1 after 6 cycles; a=0, b=x -> 0.
